// File: rtl/mem_dma_copier.sv
// Block-copy SRAM master: reads src..src+len-1 and writes dst..dst+len-1, 3 cycles per word.
// Optional MEM_DMA_FILL_EN adds a 1-cycle-per-word pattern fill mode selected by 'fill' at start.
module mem_dma_copier #(
   parameter int A_BITS = 10,
   parameter int D_BITS = 16
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic [A_BITS-1:0] src,
   input  logic [A_BITS-1:0] dst,
   input  logic [A_BITS-1:0] len,
   input  logic              fill,
   input  logic [D_BITS-1:0] pattern,
   output logic              busy,
   output logic              done,
   output logic              read,
   output logic              write,
   output logic [A_BITS-1:0] address,
   output logic [D_BITS-1:0] data_out,
   input  logic [D_BITS-1:0] data_in
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

   state_t            state_q, state_d;
   logic [A_BITS-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic [A_BITS-1:0] idx_q, idx_d, addr_q, addr_d;
   logic [D_BITS-1:0] dout_q, dout_d;
   logic              start_fill, fill_mode;
   logic [D_BITS-1:0] fill_value;

`ifdef MEM_DMA_FILL_EN
   logic              fill_q, fill_d;
   logic [D_BITS-1:0] pattern_q, pattern_d;
   assign start_fill = fill;
   assign fill_mode  = fill_q;
   assign fill_value = pattern_q;
`else
   logic unused_fill;
   assign unused_fill = ^{fill, pattern};
   assign start_fill  = 1'b0;
   assign fill_mode   = 1'b0;
   assign fill_value  = '0;
`endif

   // address/data_out are set on the transition into the state that uses them
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
`ifdef MEM_DMA_FILL_EN
      fill_d    = fill_q;
      pattern_d = pattern_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               src_d = src;
               dst_d = dst;
               len_d = len;
               idx_d = '0;
`ifdef MEM_DMA_FILL_EN
               fill_d    = fill;
               pattern_d = pattern;
`endif
               if (len == '0) begin
                  state_d = DONE;
               end else if (start_fill) begin
                  state_d = WR;
                  addr_d  = dst;
                  dout_d  = pattern;
               end else begin
                  state_d = RD;
                  addr_d  = src;
               end
            end
         end
         RD: state_d = CAP;
         CAP: begin
            state_d = WR;
            addr_d  = dst_q + idx_q;
            dout_d  = data_in;
         end
         WR: begin
            idx_d = idx_q + 1'b1;
            if (idx_d == len_q) begin
               state_d = DONE;
            end else if (fill_mode) begin
               state_d = WR;
               addr_d  = dst_q + idx_d;
               dout_d  = fill_value;
            end else begin
               state_d = RD;
               addr_d  = src_q + idx_d;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
`ifdef MEM_DMA_FILL_EN
         fill_q    <= 1'b0;
         pattern_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
`ifdef MEM_DMA_FILL_EN
         fill_q    <= fill_d;
         pattern_q <= pattern_d;
`endif
      end
   end

   assign read     = (state_q == RD);
   assign write    = (state_q == WR);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign address  = addr_q;
   assign data_out = dout_q;

endmodule

// File: tb/tb_mem_dma_copier.sv
// Randomized self-checking bench for mem_dma_copier against an array-level copy/fill model.
module tb_mem_dma_copier;

   localparam int AW = 10;
   localparam int DW = 16;
`ifdef MEM_DMA_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          nrst, start, fill;
   logic [AW-1:0] src, dst, len, address;
   logic [DW-1:0] pattern, data_out, data_in;
   logic          busy, done, read, write;

   logic [DW-1:0] mem [1024];
   logic [DW-1:0] rd_q;
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_dma_copier #(.A_BITS(AW), .D_BITS(DW)) dut (
      .clk(clk), .nrst(nrst), .start(start), .src(src), .dst(dst), .len(len),
      .fill(fill), .pattern(pattern), .busy(busy), .done(done), .read(read),
      .write(write), .address(address), .data_out(data_out), .data_in(data_in)
   );

   // SRAM with one-cycle read latency plus a preload port used only while the DUT is idle
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (write) mem[address] <= data_out;
      if (read) rd_q <= mem[address];
   end
   assign data_in = rd_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic poke(input int a, input logic [DW-1:0] v);
      pre_addr = a[AW-1:0];
      pre_data = v;
      pre_we   = 1'b1;
      @(posedge clk); #1;
      pre_we   = 1'b0;
   endtask

   function automatic logic [31:0] acc(input bit w, input int a, input logic [DW-1:0] v);
      return {5'd0, w, a[9:0], v};
   endfunction

   // rst_after_words > 0 pulls nrst low once that many words have been written
   task automatic run_xfer(input int s, input int d, input int l, input int f,
                           input logic [DW-1:0] p, input bit extra, input int rst_after_words);
      logic [DW-1:0] rm [1024];
      logic [31:0]   expq[$];
      logic [31:0]   obsq[$];
      bit  do_fill, fin;
      int  exp_done, cyc, done_at, n_done, n_busy, both, bound, nwords, n_wr, mism;
      logic [DW-1:0] v;

      do_fill = (f != 0) && FILL_EN;
      nwords  = (rst_after_words > 0) ? rst_after_words : l;
      for (int i = 0; i < 1024; i++) rm[i] = mem[i];
      for (int k = 0; k < nwords; k++) begin
         v = do_fill ? p : rm[(s + k) % 1024];
         if (!do_fill) expq.push_back(acc(1'b0, (s + k) % 1024, '0));
         rm[(d + k) % 1024] = v;
         expq.push_back(acc(1'b1, (d + k) % 1024, v));
      end
      exp_done = (l == 0) ? 1 : (do_fill ? l + 1 : 3 * l + 1);

      src = s[AW-1:0]; dst = d[AW-1:0]; len = l[AW-1:0];
      fill = (f != 0); pattern = p; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src = $urandom; dst = $urandom; len = $urandom; fill = $urandom; pattern = $urandom;

      cyc = 0; done_at = -1; n_done = 0; n_busy = 0; both = 0; n_wr = 0; fin = 1'b0;
      bound = 3 * l + 10;
      while (!fin && cyc < bound) begin
         @(negedge clk);
         cyc++;
         if (read && write) both++;
         if (busy) n_busy++;
         if (done) begin n_done++; if (done_at < 0) done_at = cyc; end
         if (read)  obsq.push_back(acc(1'b0, int'(address), '0));
         if (write) begin obsq.push_back(acc(1'b1, int'(address), data_out)); n_wr++; end
         if (extra && cyc == 2) begin start = 1'b1; src = $urandom; len = 1; end
         if (extra && cyc == 3) start = 1'b0;
         if (rst_after_words > 0 && n_wr == rst_after_words) begin
            nrst = 1'b0;
            @(negedge clk);
            check("rst_ctl", {28'd0, read, write, busy, done}, 32'd0);
            check("rst_addr", {22'd0, address}, 32'd0);
            check("rst_dout", {16'd0, data_out}, 32'd0);
            for (int j = 0; j < 6; j++) begin
               @(negedge clk);
               if (read || write || busy || done) obsq.push_back(32'hFFFF_FFFF);
            end
            nrst = 1'b1;
            fin = 1'b1;
         end
         if (done_at > 0 && cyc >= done_at) fin = 1'b1;
      end

      if (rst_after_words == 0) begin
         check("done_cycle", done_at, exp_done);
         check("busy_cycles", n_busy, exp_done);
         check("done_pulses", n_done, 1);
         @(negedge clk);
         check("idle_after", {28'd0, read, write, busy, done}, 32'd0);
      end
      check("rd_wr_both", both, 0);
      check("n_access", obsq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < obsq.size(); i++)
         check("access", obsq[i], expq[i]);
      @(posedge clk); #1;
      mism = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== rm[i]) mism++;
      check("mem_image", mism, 0);
      $display("xfer src=%0d dst=%0d len=%0d fill=%0d extra=%0d rst=%0d done_at=%0d accesses=%0d",
               s, d, l, f, extra, rst_after_words, done_at, obsq.size());
   endtask

   initial begin
      nrst = 1'b0; start = 1'b0; fill = 1'b0; src = '0; dst = '0; len = '0;
      pattern = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      @(posedge clk); #1;
      for (int i = 0; i < 1024; i++) poke(i, DW'($urandom));
      @(negedge clk);
      check("reset_ctl", {28'd0, read, write, busy, done}, 32'd0);
      check("reset_addr", {22'd0, address}, 32'd0);
      check("reset_dout", {16'd0, data_out}, 32'd0);
      @(posedge clk); #1;
      nrst = 1'b1;
      @(posedge clk); #1;

      poke(0, 16'h1111); poke(1, 16'h2222); poke(2, 16'h3333); poke(3, 16'h4444);
      run_xfer(0, 100, 4, 0, 16'h0, 1'b0, 0);
      check("basic_last", {16'd0, mem[103]}, 32'h4444);
      run_xfer(5, 6, 0, 0, 16'h0, 1'b0, 0);
      poke(1022, 16'hAAAA); poke(1023, 16'hBBBB); poke(0, 16'hCCCC);
      run_xfer(1022, 200, 3, 0, 16'h0, 1'b0, 0);
      check("wrap_word", {16'd0, mem[202]}, 32'hCCCC);
      poke(10, 16'd7); poke(11, 16'd8);
      run_xfer(10, 11, 2, 0, 16'h0, 1'b0, 0);
      check("overlap", {16'd0, mem[12]}, 32'd7);
      run_xfer(700, 50, 5, 1, 16'hBEEF, 1'b0, 0);
      run_xfer(20, 500, 4, 0, 16'h0, 1'b1, 0);
      run_xfer(300, 400, 4, 0, 16'h0, 1'b0, 2);

      for (int t = 0; t < 25; t++)
         run_xfer($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 12),
                  $urandom_range(0, 1), DW'($urandom), t % 5 == 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
